// File: rtl/video_pkg.sv
// Shared video constants and types for the scanout block.
// Holds the default 640x480 timing, the 2-bit-index colour palette, the border
// colour used outside the 256x256 image window, and the {hc, vc} position struct.
package video_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned IMG_X0_DEF   = 192;
  localparam int unsigned IMG_Y0_DEF   = 112;

  // Counter width; wide enough for any sensible total up to 4095.
  localparam int unsigned POS_W = 12;

  localparam logic [23:0] PALETTE [4] = '{24'h102030, 24'hF02010, 24'h20E040, 24'hFFFFFF};
  localparam logic [23:0] BORDER_RGB  = 24'h404040;

  typedef struct packed {
    logic [POS_W-1:0] hc;
    logic [POS_W-1:0] vc;
  } pos_t;

endpackage

// File: rtl/video_timing.sv
// Raster timing generator.
// Owns the horizontal/vertical counters and decodes visible, sync-active and
// frame-start for the current position. All decodes are gated by en, so a
// disabled scan presents an idle position.
// Ports:
//   clk, rst_n   pixel clock, async active-low reset
//   en           scan enable; low holds hc = vc = 0
//   pos          current {hc, vc}
//   visible      hc < H_ACTIVE and vc < V_ACTIVE
//   hs_act       horizontal sync window (active-high, polarity applied later)
//   vs_act       vertical sync window (active-high)
//   frame_start  position (0,0) with en high
module video_timing
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output pos_t pos,
  output logic visible,
  output logic hs_act,
  output logic vs_act,
  output logic frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > (1 << POS_W) || V_TOTAL > (1 << POS_W)) begin : g_bad_total
    $error("video_timing: totals exceed counter width");
  end

  logic [POS_W-1:0] hc, vc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc <= '0;
      vc <= '0;
    end else if (!en) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == POS_W'(H_TOTAL - 1)) begin
      hc <= '0;
      vc <= (vc == POS_W'(V_TOTAL - 1)) ? '0 : vc + 1'b1;
    end else begin
      hc <= hc + 1'b1;
    end
  end

  always_comb begin
    pos         = '{hc: hc, vc: vc};
    visible     = en && (hc < POS_W'(H_ACTIVE)) && (vc < POS_W'(V_ACTIVE));
    hs_act      = en && (hc >= POS_W'(H_ACTIVE + H_FP))
                     && (hc <  POS_W'(H_ACTIVE + H_FP + H_SYNC));
    vs_act      = en && (vc >= POS_W'(V_ACTIVE + V_FP))
                     && (vc <  POS_W'(V_ACTIVE + V_FP + V_SYNC));
    frame_start = en && (hc == '0) && (vc == '0);
  end

endmodule

// File: rtl/scanout_pipe.sv
// Frame-buffer scanout pipeline.
// Windows a 256x256 2-bit image into the visible raster, issues frame-buffer
// reads one stage ahead, maps pixel indices through the palette and delays the
// sync/enable strobes so every output lines up 3 clk after its counter position.
// Ports:
//   clk, rst_n     pixel clock, async active-low reset
//   en             scan enable
//   rd_addr        {img_y, img_x} read address, held while rd_ce is low
//   rd_ce, rd_oce  read / output clock enables (rd_oce tied high)
//   rd_data        palette index, valid one clk after rd_addr/rd_ce
//   hsync, vsync   sync outputs, active level SYNC_POL
//   de             data enable on visible pixels
//   rgb            {R8,G8,B8}
//   frame_start    one-clk pulse aligned with output pixel (0,0)
module scanout_pipe
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned IMG_X0   = IMG_X0_DEF,
  parameter int unsigned IMG_Y0   = IMG_Y0_DEF,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] rd_addr,
  output logic        rd_ce,
  output logic        rd_oce,
  input  logic [1:0]  rd_data,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [23:0] rgb,
  output logic        frame_start
);

  if (IMG_X0 + 256 > H_ACTIVE) begin : g_bad_x
    $error("scanout_pipe: IMG_X0 + 256 exceeds H_ACTIVE");
  end
  if (IMG_Y0 + 256 > V_ACTIVE) begin : g_bad_y
    $error("scanout_pipe: IMG_Y0 + 256 exceeds V_ACTIVE");
  end

  pos_t pos;
  logic visible, hs_act, vs_act, fs_act;

  video_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .pos         (pos),
    .visible     (visible),
    .hs_act      (hs_act),
    .vs_act      (vs_act),
    .frame_start (fs_act)
  );

  logic       in_window;
  logic [7:0] img_x, img_y;

  always_comb begin
    in_window = visible
             && (pos.hc >= POS_W'(IMG_X0)) && (pos.hc < POS_W'(IMG_X0 + 256))
             && (pos.vc >= POS_W'(IMG_Y0)) && (pos.vc < POS_W'(IMG_Y0 + 256));
    img_x     = 8'(pos.hc - POS_W'(IMG_X0));
    img_y     = 8'(pos.vc - POS_W'(IMG_Y0));
  end

  // Strobe shift registers: index 0 is stage 1, index 2 drives the outputs.
  // vis/win stop at stage 2 because they only steer the stage-3 colour mux.
  logic [2:0] hs_sr, vs_sr, fs_sr;
  logic [1:0] vis_sr, win_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      rd_ce   <= 1'b0;
      hs_sr   <= '0;
      vs_sr   <= '0;
      fs_sr   <= '0;
      vis_sr  <= '0;
      win_sr  <= '0;
      de      <= 1'b0;
      rgb     <= '0;
    end else begin
      rd_ce <= in_window;
      if (in_window) begin
        rd_addr <= {img_y, img_x};
      end
      hs_sr  <= {hs_sr[1:0], hs_act};
      vs_sr  <= {vs_sr[1:0], vs_act};
      fs_sr  <= {fs_sr[1:0], fs_act};
      vis_sr <= {vis_sr[0], visible};
      win_sr <= {win_sr[0], in_window};
      de     <= vis_sr[1];
      if (win_sr[1]) begin
        rgb <= PALETTE[rd_data];
      end else if (vis_sr[1]) begin
        rgb <= BORDER_RGB;
      end else begin
        rgb <= '0;
      end
    end
  end

  // Sync flags are stored active-high so reset leaves the pins inactive.
  assign hsync       = ~(hs_sr[2] ^ SYNC_POL);
  assign vsync       = ~(vs_sr[2] ^ SYNC_POL);
  assign frame_start = fs_sr[2];
  assign rd_oce      = 1'b1;

endmodule

// File: tb/tb_scanout_pipe.sv
// Bench for scanout_pipe with a reduced raster so two frames fit in a short run.
module tb_scanout_pipe;

  localparam int HA = 260, HFP = 2, HS = 4, HBP = 2;
  localparam int VA = 258, VFP = 1, VS = 2, VBP = 1;
  localparam int X0 = 4, Y0 = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam logic [23:0] TP0 = 24'h102030, TP1 = 24'hF02010, TP2 = 24'h20E040;
  localparam logic [23:0] TP3 = 24'hFFFFFF, TBORDER = 24'h404040;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] rd_addr;
  logic        rd_ce, rd_oce;
  logic [1:0]  rd_data = 2'd0;
  logic        hsync, vsync, de, frame_start;
  logic [23:0] rgb;

  scanout_pipe #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
    .IMG_X0   (X0), .IMG_Y0 (Y0), .SYNC_POL (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .rd_addr     (rd_addr),
    .rd_ce       (rd_ce),
    .rd_oce      (rd_oce),
    .rd_data     (rd_data),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .rgb         (rgb),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] mem_f(input logic [15:0] a);
    return a[1:0] ^ a[9:8];
  endfunction

  function automatic logic [23:0] tb_pal(input logic [1:0] i);
    case (i)
      2'd0:    return TP0;
      2'd1:    return TP1;
      2'd2:    return TP2;
      default: return TP3;
    endcase
  endfunction

  // Frame-buffer model: registered read, one clk latency.
  always @(posedge clk) if (rd_ce) rd_data <= mem_f(rd_addr);

  // ---------------- scoreboard ----------------
  typedef struct {
    int hc; int vc; bit en;
    bit hs; bit vs; bit de; logic [23:0] rgb; bit fs;
  } exp_t;

  exp_t q[$];
  int   mhc = 0, mvc = 0;

  function automatic exp_t model(input int hc, input int vc, input bit e);
    exp_t r;
    bit vis, win;
    logic [15:0] a;
    vis = e && hc < HA && vc < VA;
    win = vis && hc >= X0 && hc < X0 + 256 && vc >= Y0 && vc < Y0 + 256;
    a = {8'(vc - Y0), 8'(hc - X0)};
    r.hc  = hc; r.vc = vc; r.en = e;
    r.hs  = !(e && hc >= HA + HFP && hc < HA + HFP + HS);
    r.vs  = !(e && vc >= VA + VFP && vc < VA + VFP + VS);
    r.de  = vis;
    r.rgb = win ? tb_pal(mem_f(a)) : (vis ? TBORDER : 24'h0);
    r.fs  = e && hc == 0 && vc == 0;
    return r;
  endfunction

  // Each edge pushes the expectation for the cycle that just closed; it
  // reaches the pins three edges later. During reset two idle entries stand
  // for the cleared pipeline.
  always @(posedge clk) begin
    if (!rst_n) begin
      mhc = 0; mvc = 0;
      q.delete();
      q.push_back(model(0, 0, 1'b0));
      q.push_back(model(0, 0, 1'b0));
    end else begin
      q.push_back(model(mhc, mvc, en));
      if (!en) begin
        mhc = 0; mvc = 0;
      end else if (mhc == HT - 1) begin
        mhc = 0;
        mvc = (mvc == VT - 1) ? 0 : mvc + 1;
      end else begin
        mhc = mhc + 1;
      end
    end
  end

  // Per-line aggregation keeps a wrong line to one report.
  int grp_n = 0, grp_bad = 0, f_hc, f_vc;
  logic [3:0]  f_got, f_want;
  logic [23:0] f_got_rgb, f_want_rgb;

  task automatic close_grp(input int vc);
    if (grp_n > 0) begin
      n_cmp++;
      if (grp_bad != 0) begin
        n_bad++;
        $display("FAIL scoreboard line vc=%0d: %0d of %0d cycles wrong, first (%0d,%0d) got hs/vs/de/fs=%b rgb=%h want %b %h",
                 vc, grp_bad, grp_n, f_hc, f_vc, f_got, f_got_rgb, f_want, f_want_rgb);
      end
    end
    grp_n = 0; grp_bad = 0;
  endtask

  typedef struct { int hc; int vc; logic [23:0] rgb; bit de; } vec_t;
  vec_t tbl[11];

  always @(negedge clk) begin
    exp_t e, b;
    if (rst_n && q.size() == 3) begin
      b = q[$];
      if (b.en && b.hc == 0 && b.vc == 0) check("rd_ce at (0,0)", rd_ce, 0);
      if (b.en && b.hc == X0 && b.vc == Y0) begin
        check("rd_ce window origin", rd_ce, 1);
        check("rd_addr window origin", rd_addr, 16'h0000);
      end
      if (b.en && b.hc == X0 + 255 && b.vc == Y0 + 1) begin
        check("rd_ce (255,1)", rd_ce, 1);
        check("rd_addr (255,1)", rd_addr, 16'h01FF);
      end
      if (b.en && b.hc == X0 + 256 && b.vc == Y0 + 1) begin
        check("rd_ce past window", rd_ce, 0);
        check("rd_addr held past window", rd_addr, 16'h01FF);
      end
      e = q.pop_front();
      grp_n++;
      if (hsync !== e.hs || vsync !== e.vs || de !== e.de || frame_start !== e.fs
          || rgb !== e.rgb) begin
        if (grp_bad == 0) begin
          f_hc = e.hc; f_vc = e.vc;
          f_got = {hsync, vsync, de, frame_start}; f_got_rgb = rgb;
          f_want = {e.hs, e.vs, e.de, e.fs};       f_want_rgb = e.rgb;
        end
        grp_bad++;
      end
      if (e.en) begin
        foreach (tbl[i]) begin
          if (tbl[i].hc == e.hc && tbl[i].vc == e.vc) begin
            check($sformatf("table rgb (%0d,%0d)", e.hc, e.vc), rgb, tbl[i].rgb);
            check($sformatf("table de (%0d,%0d)", e.hc, e.vc), de, tbl[i].de);
          end
        end
        if (e.hc == HT - 1) close_grp(e.vc);
      end
    end
  end

  // ---------------- waveform measurements over two frames ----------------
  bit meas_on = 0;
  int cyc = 0, fs_cnt = 0, last_fs = -1, last_hf = -1, last_vf = -1, de_st = 0, de_lines = 0;
  logic hs_p = 1'b1, vs_p = 1'b1, de_p = 1'b0;

  always @(negedge clk) begin
    if (meas_on) begin
      cyc++;
      if (hs_p && !hsync) begin
        if (last_hf >= 0) check("hsync period", cyc - last_hf, HT);
        last_hf = cyc;
      end
      if (!hs_p && hsync && last_hf >= 0) check("hsync low width", cyc - last_hf, HS);
      if (vs_p && !vsync) begin
        if (last_fs >= 0) check("vsync start after frame", cyc - last_fs, (VA + VFP) * HT);
        last_vf = cyc;
      end
      if (!vs_p && vsync && last_vf >= 0) check("vsync low width", cyc - last_vf, VS * HT);
      if (!de_p && de) de_st = cyc;
      if (de_p && !de) begin
        check("de width", cyc - de_st, HA);
        de_lines++;
      end
      if (frame_start) begin
        if (last_fs >= 0) begin
          check("frame period", cyc - last_fs, HT * VT);
          check("de lines per frame", de_lines, VA);
        end
        de_lines = 0;
        last_fs = cyc;
        fs_cnt++;
      end
      hs_p = hsync; vs_p = vsync; de_p = de;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    bit hit;
    // {hc, vc, rgb, de}; image pixel values follow mem = x[1:0] ^ y[1:0].
    tbl[0]  = '{X0 + 0,   Y0 + 0,   TP0, 1'b1};
    tbl[1]  = '{X0 + 1,   Y0 + 0,   TP1, 1'b1};
    tbl[2]  = '{X0 + 255, Y0 + 0,   TP3, 1'b1};
    tbl[3]  = '{X0 + 0,   Y0 + 1,   TP1, 1'b1};
    tbl[4]  = '{X0 + 1,   Y0 + 1,   TP0, 1'b1};
    tbl[5]  = '{X0 + 255, Y0 + 1,   TP2, 1'b1};
    tbl[6]  = '{X0 + 0,   Y0 + 255, TP3, 1'b1};
    tbl[7]  = '{X0 + 1,   Y0 + 255, TP2, 1'b1};
    tbl[8]  = '{X0 + 255, Y0 + 255, TP0, 1'b1};
    tbl[9]  = '{0,        0,        TBORDER, 1'b1};
    tbl[10] = '{HA + 1,   10,       24'h0,   1'b0};

    repeat (3) @(negedge clk);
    check("reset hsync", hsync, 1);
    check("reset vsync", vsync, 1);
    check("reset de", de, 0);
    check("reset rgb", rgb, 0);
    check("reset frame_start", frame_start, 0);
    check("reset rd_ce", rd_ce, 0);
    check("reset rd_addr", rd_addr, 0);
    check("rd_oce tied", rd_oce, 1);

    // Two full frames.
    meas_on = 1;
    rst_n = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 80000 && fs_cnt < 2; i++) @(negedge clk);
    check("two frame_starts seen", fs_cnt >= 2, 1);
    meas_on = 0;

    // Drop en mid-frame.
    hit = 0;
    for (int i = 0; i < 20000 && !hit; i++) begin
      @(negedge clk);
      hit = (mhc == 100 && mvc == 20);
    end
    check("reached (100,20)", hit, 1);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("en drop rd_ce", rd_ce, 0);
    check("en drop hsync", hsync, 1);
    check("en drop vsync", vsync, 1);
    check("en drop de", de, 0);
    check("en drop rgb", rgb, 0);
    check("en drop frame_start", frame_start, 0);
    repeat (5) @(negedge clk);
    en = 1'b1;
    k = 0;
    for (int i = 1; i <= 10 && k == 0; i++) begin
      @(posedge clk);
      #1;
      if (frame_start) k = i;
    end
    check("frame_start edges after en rise", k, 3);
    check("hsync at restart", hsync, 1);
    check("vsync at restart", vsync, 1);

    // Asynchronous reset mid-line.
    hit = 0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge clk);
      hit = (mhc == 200);
    end
    check("reached hc=200", hit, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst hsync", hsync, 1);
    check("async rst vsync", vsync, 1);
    check("async rst de", de, 0);
    check("async rst rgb", rgb, 0);
    check("async rst frame_start", frame_start, 0);
    check("async rst rd_ce", rd_ce, 0);
    check("async rst rd_addr", rd_addr, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    // Pulse is presented after the 3rd edge, i.e. sampled at the 4th.
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("frame_start after release edge %0d", i), frame_start, (i == 3));
    end

    repeat (300) @(negedge clk);
    close_grp(-1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scanout_pipe.md
SCANOUT_PIPE -- requirements
Module: scanout_pipe

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter H_FP/H_SYNC/H_BP, defaults 16/96/48: horizontal porch and sync widths in clocks.
REQ-003 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 Parameter V_FP/V_SYNC/V_BP, defaults 10/2/33: vertical porch and sync widths in lines.
REQ-005 Parameter IMG_X0, default 192: first visible column of the 256x256 image window.
REQ-006 Parameter IMG_Y0, default 112: first visible line of the image window.
REQ-007 Parameter SYNC_POL, default 0: active level of hsync and vsync.
REQ-008 Port clk, input, 1: pixel clock; single clock domain for the whole block.
REQ-009 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-010 Port en, input, 1: scanout enable.
REQ-011 Port rd_addr, output, 16: frame-buffer read address {img_y[7:0], img_x[7:0]}.
REQ-012 Port rd_ce, output, 1: frame-buffer read clock enable.
REQ-013 Port rd_oce, output, 1: frame-buffer output clock enable.
REQ-014 Port rd_data, input, 2: frame-buffer read data, valid one clk after rd_addr/rd_ce are sampled.
REQ-015 Port hsync, output, 1: horizontal sync.
REQ-016 Port vsync, output, 1: vertical sync.
REQ-017 Port de, output, 1: data enable, high on visible pixels.
REQ-018 Port rgb, output, 24: pixel colour {R8,G8,B8}.
REQ-019 Port frame_start, output, 1: one-clk pulse coinciding with output pixel (0,0).

Function
REQ-020 Horizontal counter hc SHALL count 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800), then wrap to 0 and advance vc.
REQ-021 Vertical counter vc SHALL count 0..V_TOTAL-1 (525), then wrap to 0 on the clk where hc wraps.
REQ-022 Visible SHALL mean hc<H_ACTIVE and vc<V_ACTIVE; sync is active for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), vsync analogously on vc.
REQ-023 In-window SHALL mean visible, hc-IMG_X0 in [0,255] and vc-IMG_Y0 in [0,255].
REQ-024 Stage 1 SHALL register rd_addr = {vc-IMG_Y0, hc-IMG_X0}[low 8 bits each] and rd_ce = in-window; rd_addr holds its last value while rd_ce is low.
REQ-025 Stage 2 SHALL take rd_data from the frame buffer (one clk after stage 1).
REQ-026 Stage 3 SHALL register rgb = PALETTE[rd_data] when in-window, BORDER_RGB when visible but outside the window, and 0 when not visible.
REQ-027 hsync, vsync, de and frame_start SHALL be delayed through a 3-stage shift so that they align with rgb; total latency from counter position to outputs is exactly 3 clk.
REQ-028 rd_oce SHALL be driven constant 1.
REQ-029 en low SHALL hold hc=vc=0 and force rd_ce=0; the pipeline continues to flush, so outputs reach the idle state within 3 clk.
REQ-030 Idle output state SHALL be hsync=vsync=!SYNC_POL, de=0, rgb=0, frame_start=0.
REQ-031 On an en rising edge the scan SHALL start at hc=vc=0, with frame_start asserted 3 clk later.
REQ-032 Parameter sums SHALL be checked at elaboration: IMG_X0+256<=H_ACTIVE and IMG_Y0+256<=V_ACTIVE.

Reset
REQ-033 While rst_n is low: hc=vc=0, all pipeline registers cleared, rd_addr=0, rd_ce=0, and outputs in the idle state, regardless of clk.
REQ-034 Reset deassertion mid-frame SHALL restart the scan at (0,0) on the first clk with en high.

Structure
REQ-035 Package video_pkg SHALL hold the default timing constants, the PALETTE[4] (24-bit) constant, BORDER_RGB, and the pixel-position struct {hc, vc}.
REQ-036 A single sub-module, video_timing, SHALL own hc/vc, the visible/sync decode and frame_start; scanout_pipe SHALL own the windowing, the read port and the delay pipeline.

Verification
REQ-037 Reset, then en=1 for 2 frames -> hsync period 800 clk with low width 96, vsync period 420000 clk with low width 1600, and de high for 640 clk per line on 480 lines.
REQ-038 Model the RAM with mem[a]=a[1:0]^a[9:8] -> output pixel (IMG_X0+x, IMG_Y0+y) shows PALETTE[mem[{y,x}]]; checked for x,y in {0,1,255}.
REQ-039 Visible pixel (0,0) -> rgb=BORDER_RGB, rd_ce=0; pixel (700,10) -> rgb=0, de=0.
REQ-040 Drop en at hc=300, vc=200 -> idle outputs within 3 clk; re-raise en -> frame_start exactly 3 clk later with hsync/vsync inactive.
REQ-041 Assert rst_n=0 asynchronously between clk edges at hc=400 -> outputs are idle immediately; release -> first frame_start at the 4th clk edge.
